// File: rtl/shreg_seq_ctl.sv
// Sequencer for an 8-bit universal tri-state shift/storage register.
// Each transaction parallel-loads a byte, shifts NSHIFT bits while feeding a
// serial bit, then enables the register outputs and captures the result.
// All control pins come from flops updated from the next state. The only
// exception is ser_in, which is gated straight onto sl/sr.
module shreg_seq_ctl #(
  parameter int WIDTH  = 8,
  parameter int NSHIFT = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] tx,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] qio_in,
  output logic             s1,
  output logic             s0,
  output logic             g1,
  output logic             g2,
  output logic             sl,
  output logic             sr,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The counter value on the last SHIFT cycle. It is unused when NSHIFT is 0.
  localparam logic [3:0] LAST_CNT  = (NSHIFT > 0) ? 4'(NSHIFT - 1) : 4'd0;
  localparam logic       HAS_SHIFT = (NSHIFT > 0) ? 1'b1 : 1'b0;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q;
  logic [WIDTH-1:0] bus_out_q;
  logic [WIDTH-1:0] rdata_q;
  logic             s1_q, s0_q, oe_n_q, bus_oe_q, busy_q, done_q;
  logic             sl_en_q, sr_en_q;

  // Next-state and bit-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        cnt_d = 4'd0;
        if (HAS_SHIFT) state_d = ST_SHIFT;
        else           state_d = ST_READ;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_READ;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_READ: state_d = ST_READ == state_q ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched transaction data, capture register and pin flops decoded from the next state
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      dir_q     <= 1'b0;
      bus_out_q <= '0;
      rdata_q   <= '0;
      s1_q      <= 1'b0;
      s0_q      <= 1'b0;
      oe_n_q    <= 1'b1;
      bus_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sl_en_q   <= 1'b0;
      sr_en_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // bus_out_q doubles as the latched copy of tx for the whole transaction
      if (state_q == ST_IDLE && start) begin
        bus_out_q <= tx;
        dir_q     <= dir;
      end
      if (state_q == ST_READ) begin
        rdata_q <= qio_in;
      end
      s1_q     <= 1'b0;
      s0_q     <= 1'b0;
      oe_n_q   <= 1'b1;
      bus_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sl_en_q  <= 1'b0;
      sr_en_q  <= 1'b0;
      case (state_d)
        ST_LOAD: begin
          s1_q     <= 1'b1;
          s0_q     <= 1'b1;
          bus_oe_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        ST_SHIFT: begin
          // dir_q is already latched, because SHIFT is only entered after LOAD
          s1_q    <= dir_q;
          s0_q    <= ~dir_q;
          sl_en_q <= dir_q;
          sr_en_q <= ~dir_q;
          busy_q  <= 1'b1;
        end
        ST_READ: begin
          oe_n_q <= 1'b0;
          busy_q <= 1'b1;
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign s1      = s1_q;
  assign s0      = s0_q;
  assign g1      = oe_n_q;
  assign g2      = oe_n_q;
  assign sl      = sl_en_q & ser_in;
  assign sr      = sr_en_q & ser_in;
  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;

endmodule

// File: doc/shreg_seq_ctl.md
Name: shreg_seq_ctl

Overview:
Upstream sequencer that drives the control pins of an 8-bit universal tri-state shift/storage register (sn74ls323-class) and owns its shared I/O bus.
- One transaction per start pulse, in this order: parallel-load a byte, shift NSHIFT bits left or right while feeding a serial input, then enable the register outputs and capture the result.
- The bidirectional bus is split into bus_out/bus_oe/qio_in so the block needs no inout port.

Parameters:
WIDTH, 8, register/bus width in bits.
NSHIFT, 8, shift cycles per transaction, legal range 0..15.

Ports:
clk  input  1  clock; all state changes on the rising edge.
clr  input  1  reset, synchronous, active-high.
start  input  1  request a transaction; sampled only in IDLE.
dir  input  1  shift direction, latched with start: 0 = right (s=01), 1 = left (s=10).
tx  input  WIDTH  byte to load, latched with start.
ser_in  input  1  serial bit routed to the register's serial input during SHIFT.
qio_in  input  WIDTH  register I/O pins as seen on the bus; bit0 = qa.
s1  output  1  register mode select, high bit.
s0  output  1  register mode select, low bit.
g1  output  1  register output enable 1, active-low.
g2  output  1  register output enable 2, active-low.
sl  output  1  left serial input to the register.
sr  output  1  right serial input to the register.
bus_out  output  WIDTH  load data driven onto the bus.
bus_oe  output  1  1 = this block drives the bus.
busy  output  1  high during LOAD, SHIFT and READ.
done  output  1  one-cycle pulse; rdata is valid in this cycle.
rdata  output  WIDTH  captured register contents; holds until the next capture.

Behaviour:
- State encoding: IDLE, LOAD, SHIFT, READ, DONE. Output pins are decoded from the registered state and latched data only, with no combinational path from start.
- Reset (clr=1 at an edge), mid-transaction included:
  - state goes to IDLE and the bit counter clears;
  - rdata, bus_out and the latched tx/dir go to 0; done=0, busy=0;
  - the pending transaction is discarded with no done pulse;
  - clr takes priority over start.
- Output values per state:
  - IDLE: s1s0=00 (hold), g1=g2=1, bus_oe=0, sl=sr=0.
  - LOAD: s1s0=11, g1=g2=1 (register outputs off), bus_oe=1, bus_out=latched tx. Lasts exactly 1 cycle; the register loads on the closing edge.
  - SHIFT: s1s0=01 if dir=0, 10 if dir=1; g1=g2=1; bus_oe=0.
    - dir=0: sr=ser_in, sl=0. dir=1: sl=ser_in, sr=0.
    - ser_in passes combinationally, so each shift captures the ser_in value present just before that edge.
    - The counter counts edges in SHIFT; the FSM exits after exactly NSHIFT cycles.
  - READ: s1s0=00, g1=g2=0, bus_oe=0. rdata <= qio_in on the closing edge. Lasts 1 cycle.
  - DONE: done=1, busy=0, s1s0=00, g1=g2=1. Next state is IDLE unconditionally.
- Transitions:
  - IDLE->LOAD on start=1.
  - LOAD->SHIFT if NSHIFT>0, else LOAD->READ.
  - SHIFT->READ after NSHIFT cycles.
  - READ->DONE.
  - DONE->IDLE.
- Latency: with start sampled at edge E, done is high in the cycle after edge E+NSHIFT+2. With NSHIFT=8 that is 10 edges.
- Throughput: start is ignored in LOAD, SHIFT, READ and DONE (not queued). Back-to-back transactions are therefore spaced NSHIFT+4 cycles apart.
- tx and dir changes after the start edge have no effect on the transaction in flight.
- Bus contention: bus_oe=1 and (g1=0 and g2=0) never hold in the same cycle. The bench asserts this on every cycle.

Test Plan:
1. Load/readback: NSHIFT=0, tx=8'hCA, start pulse.
   - Expect LOAD 1 cycle with bus_out=CA and bus_oe=1, then READ, then done with rdata=8'hCA.
   - Expect done 2 edges after start.
2. Right shift: NSHIFT=8, dir=0, tx=8'hFF, ser_in sequence 1,0,1,1,0,0,1,0 (one bit per SHIFT cycle).
   - Expect s1s0=01 for exactly 8 cycles, then rdata=8'hB2.
   - Expect done 10 edges after start; busy high for 10 cycles.
3. Left shift: same setup with dir=1, ser_in sequence 1,0,1,1,0,0,1,0.
   - Expect s1s0=10 for 8 cycles and sl to follow ser_in with sr=0; rdata=8'h4D.
4. Partial shift: NSHIFT=3, dir=0, tx=8'hCA, ser_in=1 throughout.
   - Expect rdata=8'h57.
   - A second start raised during SHIFT is ignored; no second LOAD before DONE->IDLE.
5. Reset mid-shift: assert clr for 1 cycle at the 4th SHIFT cycle.
   - Next cycle: IDLE, busy=0, done never pulses, rdata=0, g1=g2=1, bus_oe=0.
   - A following start behaves exactly as in scenario 2.
6. Contention/priority checks, run alongside all scenarios:
   - bus_oe and output-enable are never active together.
   - clr and start asserted in the same cycle leave the block in IDLE.
